// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared definitions for the fetch PC generator. Holds the
//            redirect-buffer state encoding and the default reset and
//            exception vectors. The CP0 block imports the same vectors.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

   // Redirect buffer state: RUN has nothing buffered, PEND holds a target.
   typedef enum logic [0:0] {
      PC_RUN  = 1'b0,
      PC_PEND = 1'b1
   } pc_state_e;

   // Default vectors. Keep them in sync with the CP0 block.
   localparam logic [31:0] c_def_reset_vec = 32'h0000_3000;
   localparam logic [31:0] c_def_exc_vec   = 32'h0000_4180;

   // Fetch addresses must be word aligned, whatever the PC width.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return (lsb != 2'b00);
   endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_buf
// Purpose  : RUN/PEND state machine with a one-entry branch target buffer.
//            A redirect that arrives while fetch is stalled is stored here
//            (newest wins) and is handed to the PC mux on the first
//            unstalled cycle. clr drops any buffered redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_buf
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            stall,
   input  logic            br_valid,
   input  logic [XLEN-1:0] br_target,
   output logic            pend,
   output logic [XLEN-1:0] pend_target
);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] tgt_q, tgt_d;

   // State and buffered-target registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PC_RUN;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   // Next state: capture on stalled redirect, release when the stall drops.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      if (clr) begin
         // Exception entry/return flushes whatever was waiting.
         state_d = PC_RUN;
         tgt_d   = '0;
      end else begin
         case (state_q)
            PC_RUN: begin
               if (stall && br_valid) begin
                  state_d = PC_PEND;
                  tgt_d   = br_target;
               end
            end
            PC_PEND: begin
               if (stall) begin
                  if (br_valid) begin
                     tgt_d = br_target;
                  end
               end else begin
                  // PC mux consumes the target this cycle.
                  state_d = PC_RUN;
               end
            end
            default: begin
               state_d = PC_RUN;
            end
         endcase
      end
   end

   assign pend        = (state_q == PC_PEND);
   assign pend_target = tgt_q;

endmodule : pc_redirect_buf
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch-stage program counter. Next-PC priority, highest first:
//            reset, exception entry, exception return, unstalled advance
//            (new redirect, buffered redirect, or sequential), stall hold.
//            Also provides PC+INC, PC+2*INC, a fetch address error flag and
//            a count of PC updates since reset.
// Options  : PC_RANGE_CHECK_EN - when defined, F_adel also flags fetch
//            addresses outside [IM_BASE, IM_BASE+IM_SIZE).
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(c_def_reset_vec),
   parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(c_def_exc_vec),
   parameter int unsigned     INC       = 4,
   parameter int unsigned     CNT_W     = 16,
   parameter logic [XLEN-1:0] IM_BASE   = XLEN'(32'h0000_3000),
   parameter logic [XLEN-1:0] IM_SIZE   = XLEN'(32'h0000_4000)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [XLEN-1:0]  br_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [XLEN-1:0]  epc_in,
   output logic [XLEN-1:0]  F_pc,
   output logic [XLEN-1:0]  F_pc4,
   output logic [XLEN-1:0]  F_pc8,
   output logic             F_adel,
   output logic             redir_pend,
   output logic [CNT_W-1:0] fetch_cnt
);

   localparam logic [XLEN-1:0] c_inc  = XLEN'(INC);
   localparam logic [XLEN-1:0] c_inc2 = XLEN'(2 * INC);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_clr;
   logic             w_pc_we;
   logic             w_buf_pend;
   logic [XLEN-1:0]  w_buf_target;
   logic             w_out_of_range;

   assign w_clr = exc_req | eret_req;

   pc_redirect_buf #(
      .XLEN (XLEN)
   ) u_redirect_buf (
      .clk         (clk),
      .reset       (reset),
      .clr         (w_clr),
      .stall       (stall),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .pend        (w_buf_pend),
      .pend_target (w_buf_target)
   );

   // Next-PC selection; the PC is written on any non-hold cycle.
   always_comb begin
      pc_d    = pc_q;
      w_pc_we = 1'b0;
      if (exc_req) begin
         pc_d    = EXC_VEC;
         w_pc_we = 1'b1;
      end else if (eret_req) begin
         pc_d    = epc_in;
         w_pc_we = 1'b1;
      end else if (!stall) begin
         w_pc_we = 1'b1;
         if (br_valid) begin
            // A fresh redirect supersedes an older buffered one.
            pc_d = br_target;
         end else if (w_buf_pend) begin
            pc_d = w_buf_target;
         end else begin
            pc_d = pc_q + c_inc;
         end
      end
      cnt_d = w_pc_we ? (cnt_q + CNT_W'(1)) : cnt_q;
   end

   // PC and fetch counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VEC;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef PC_RANGE_CHECK_EN
   // One extra bit keeps IM_BASE+IM_SIZE from wrapping at the top of memory.
   localparam logic [XLEN:0] c_im_lo = {1'b0, IM_BASE};
   localparam logic [XLEN:0] c_im_hi = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
   logic [XLEN:0] w_pc_ext;
   assign w_pc_ext       = {1'b0, pc_q};
   assign w_out_of_range = (w_pc_ext < c_im_lo) || (w_pc_ext >= c_im_hi);
`else
   // Memory window is not checked in this build.
   logic w_unused_range;
   assign w_unused_range = ^{IM_BASE, IM_SIZE};
   assign w_out_of_range = 1'b0;
`endif

   assign F_pc       = pc_q;
   assign F_pc4      = pc_q + c_inc;
   assign F_pc8      = pc_q + c_inc2;
   assign F_adel     = is_misaligned(pc_q[1:0]) | w_out_of_range;
   assign redir_pend = w_buf_pend;
   assign fetch_cnt  = cnt_q;

endmodule : pc_gen
`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-stage program counter with prioritised next-PC selection: sequential, branch redirect, exception vector, and exception return.
Branch redirects that arrive while fetch is stalled are buffered, not dropped. The buffered redirect is applied on the first unstalled cycle.
Sits at the head of the F stage. Feeds the instruction memory and the F/D pipeline register. Takes controls from the D/E stage branch unit and from the CP0 block.

Parameters:
XLEN, 32, PC/address width in bits (>= 8)
RESET_VEC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, exception handler entry address
INC, 4, sequential increment in bytes (power of two, >= 4)
CNT_W, 16, width of fetch counter
IM_BASE, 32'h0000_3000, instruction memory base (used only with the optional feature)
IM_SIZE, 32'h0000_4000, instruction memory size in bytes (used only with the optional feature)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC (hazard unit)
br_valid  input  1  branch/jump redirect request
br_target  input  XLEN  redirect target
exc_req  input  1  exception taken, jump to EXC_VEC
eret_req  input  1  return from exception
epc_in  input  XLEN  return address from CP0
F_pc  output  XLEN  current fetch PC
F_pc4  output  XLEN  F_pc + INC
F_pc8  output  XLEN  F_pc + 2*INC
F_adel  output  1  fetch address error for current F_pc
redir_pend  output  1  buffered redirect waiting for stall release
fetch_cnt  output  CNT_W  count of PC advances since reset

Behaviour:
- Interface fixed: single clock clk; reset is synchronous and active-high (reset=1 sampled at rising edge clk).
- Reset values: F_pc=RESET_VEC, redir_pend=0, pending target=0, fetch_cnt=0, state=RUN.
- F_pc4, F_pc8 and F_adel are combinational from the PC register. The PC register itself has 1-cycle update latency.
- Arithmetic is modulo 2^XLEN. PC wrap-around at top of address space is silent.
- Per-edge priority, highest first: reset > exc_req > eret_req > (stall=0 path) > stall hold.
- exc_req=1: PC<=EXC_VEC regardless of stall. Pending is cleared and state goes to RUN.
- eret_req=1 (exc_req=0): PC<=epc_in regardless of stall. Pending is cleared and state goes to RUN.
- If exc_req and eret_req are both 1, exc_req wins.
- States: RUN (no buffered redirect), PEND (redirect buffered). redir_pend = (state==PEND).
- RUN, stall=0: br_valid ? PC<=br_target : PC<=PC+INC.
- RUN, stall=1: PC is held. If br_valid=1, capture br_target and go to PEND.
- PEND, stall=1: PC is held. If br_valid=1, overwrite the buffered target (newest wins).
- PEND, stall=0: PC<=(br_valid ? br_target : buffered target). Return to RUN.
- fetch_cnt increments by 1 on every edge where PC is written (any non-reset, non-hold update) and wraps to 0.
- Without the optional feature, F_adel = (F_pc mod 4 != 0).
- Reset asserted mid-PEND discards the buffered redirect.

Optional Feature:
PC_RANGE_CHECK_EN
- Defined: F_adel = misaligned OR F_pc < IM_BASE OR F_pc >= IM_BASE+IM_SIZE. The comparison is unsigned, XLEN+1-bit safe.
- Undefined: F_adel = misaligned only; IM_BASE and IM_SIZE are unused.
- No effect on PC sequencing in either case. The exception is raised downstream.

Decomposition:
- Shared package pc_pkg holds the state encoding (PC_RUN=1'b0, PC_PEND=1'b1) and the default RESET_VEC/EXC_VEC constants, shared with the CP0 block.
- One natural sub-module, pc_redirect_buf: the RUN/PEND FSM plus the buffered target register. It exposes the pending flag and target, and takes a clear input.
- The PC register, next-PC mux, counter and adel logic stay in pc_gen.

Test Plan:
1. Reset, then 3 unstalled cycles with no requests -> F_pc 0x3000,0x3004,0x3008,0x300C; F_pc8=0x3014; fetch_cnt=3.
2. Redirect while running: stall=0, br_valid=1, br_target=0x3100 -> next F_pc=0x3100; redir_pend stays 0.
3. Redirect during stall, overwritten: stall=1 for 3 cycles; br_target=0x3200 on cycle 1, 0x3300 on cycle 2 -> F_pc held; redir_pend=1; after stall drops, F_pc=0x3300, redir_pend=0, fetch_cnt +1 only.
4. Exception overrides a pending redirect: PEND with 0x3200 buffered, stall=1, exc_req=1 -> F_pc=0x4180, redir_pend=0. Then eret_req=1, epc_in=0x3008 -> F_pc=0x3008.
5. Simultaneous exc_req=1 and eret_req=1 and br_valid=1 -> F_pc=0x4180. Separately, br_target=0x3102 -> F_adel=1 the next cycle.
6. With PC_RANGE_CHECK_EN defined: br_target=0x2FFC -> F_adel=1; br_target=0x7000 -> F_adel=1; br_target=0x6FFC -> F_adel=0.
